puf_crp_collector: RTL

PUF_CRP_COLLECTOR -- requirements
Module: puf_crp_collector

---
 rtl/puf_pkg.sv | 27 ++
 rtl/puf_lfsr64.sv | 24 ++
 rtl/puf_crp_collector.sv | 109 ++++++++++
 3 files changed

// File: rtl/puf_pkg.sv
// Shared definitions for the arbiter-PUF challenge/response collector.
package puf_pkg;

   localparam int unsigned CHAL_W = 64;

   // Feedback taps of the 64-bit Fibonacci LFSR that walks the challenge space
   localparam int unsigned TAP_A = 63;
   localparam int unsigned TAP_B = 62;
   localparam int unsigned TAP_C = 60;
   localparam int unsigned TAP_D = 59;

   // Substitute for an all-zero seed, which would lock the LFSR
   localparam logic [CHAL_W-1:0] ZERO_SEED_SUB = 64'h0000_0000_0000_0001;

   // Collector FSM states; encodings fixed for compatibility with existing tooling
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_OUTPUT = 2'd3
   } puf_state_e;

   function automatic logic [CHAL_W-1:0] lfsr_next(input logic [CHAL_W-1:0] c);
      return {c[CHAL_W-2:0], c[TAP_A] ^ c[TAP_B] ^ c[TAP_C] ^ c[TAP_D]};
   endfunction

endpackage

// File: rtl/puf_lfsr64.sv
// 64-bit challenge LFSR: seed load (zero seed replaced) and single-step advance.
module puf_lfsr64
   import puf_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [CHAL_W-1:0] seed,
   output logic [CHAL_W-1:0] state
);

   // Load has priority over step; otherwise the register holds its value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= '0;
      end else if (load) begin
         state <= (seed == '0) ? ZERO_SEED_SUB : seed;
      end else if (step) begin
         state <= lfsr_next(state);
      end
   end

endmodule

// File: rtl/puf_crp_collector.sv
// Drives arbiter-PUF challenges from an LFSR, lets each settle, and shifts the
// response bits into a key that is handed off with a valid/ready handshake.
module puf_crp_collector
   import puf_pkg::*;
#(
   parameter int unsigned SETTLE    = 4,
   parameter int unsigned RESP_BITS = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [CHAL_W-1:0]    seed,
   output logic [CHAL_W-1:0]    challenge,
   input  logic                 puf_response,
   output logic                 busy,
   output logic [RESP_BITS-1:0] key,
   output logic                 key_valid,
   input  logic                 key_ready
);

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
   localparam logic [6:0] BIT_LAST    = 7'(RESP_BITS - 1);

   puf_state_e           state_q;
   puf_state_e           state_d;
   logic [7:0]           settle_cnt;
   logic [6:0]           bit_cnt;
   logic [RESP_BITS-1:0] key_q;
   logic [RESP_BITS-1:0] key_shift;
   logic                 accept;
   logic                 sampling;

   assign accept    = (state_q == ST_IDLE) && start;
   assign sampling  = (state_q == ST_SAMPLE);
   assign busy      = (state_q != ST_IDLE);
   assign key_valid = (state_q == ST_OUTPUT);
   assign key       = key_q;

   // First collected bit must end up in the MSB, so shift toward the MSB
   if (RESP_BITS == 1) begin : g_key_one
      assign key_shift = puf_response;
   end else begin : g_key_many
      assign key_shift = {key_q[RESP_BITS-2:0], puf_response};
   end

   puf_lfsr64 u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept),
      .step  (sampling),
      .seed  (seed),
      .state (challenge)
   );

   // Next-state logic for the collection sequence
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_SETTLE;
         ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_d = ST_SAMPLE;
         ST_SAMPLE: state_d = (bit_cnt == BIT_LAST) ? ST_OUTPUT : ST_SETTLE;
         ST_OUTPUT: if (key_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Settle counter: counts cycles spent in SETTLE, zero everywhere else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= '0;
      end else if (state_q == ST_SETTLE && settle_cnt != SETTLE_LAST) begin
         settle_cnt <= settle_cnt + 8'd1;
      end else begin
         settle_cnt <= '0;
      end
   end

   // Bit counter: cleared when a run is accepted, advanced once per sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
      end else if (accept) begin
         bit_cnt <= '0;
      end else if (sampling) begin
         bit_cnt <= bit_cnt + 7'd1;
      end
   end

   // Key register: cleared on accept, shifted on sample, held otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q <= '0;
      end else if (accept) begin
         key_q <= '0;
      end else if (sampling) begin
         key_q <= key_shift;
      end
   end

endmodule
